// File: rtl/axi_modport_slave_if.sv
// rtl/axi_modport_slave_if.sv - AXI bus bundle with master/slave modports
// Purpose: groups the five AXI channels (AW, W, B, AR, R) of the memory slave.
// Ports:   none; master modport drives AW/W/AR payload+valid and B/R ready,
//          slave modport drives AW/W/AR ready and B/R payload+valid.
interface axi_modport_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [7:0]              AWID;
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [7:0]              AWLEN;
    logic [2:0]              AWSIZE;
    logic [1:0]              AWBURST;
    logic                    AWVALID;
    logic                    AWREADY;

    logic [7:0]              WID;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WLAST;
    logic                    WVALID;
    logic                    WREADY;

    logic [7:0]              BID;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;

    logic [7:0]              ARID;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [7:0]              ARLEN;
    logic [2:0]              ARSIZE;
    logic [1:0]              ARBURST;
    logic                    ARVALID;
    logic                    ARREADY;

    logic [7:0]              RID;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RLAST;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
        output WID, WDATA, WSTRB, WLAST, WVALID, input WREADY,
        input  BID, BRESP, BVALID, output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
        input  WID, WDATA, WSTRB, WLAST, WVALID, output WREADY,
        output BID, BRESP, BVALID, input BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
    );
endinterface

// File: rtl/axi_modport_slave.sv
// rtl/axi_modport_slave.sv - AXI slave endpoint backed by a word-addressed memory
// Purpose: independent write (W_IDLE/W_DATA/W_RESP) and read (R_IDLE/R_DATA)
//          FSMs serving FIXED/INCR/WRAP bursts with byte strobes, OKAY/SLVERR.
// Ports:   ACLK    - clock, rising edge
//          ARESETn - asynchronous reset, active HIGH despite the name
//          bus     - axi_modport_slave_if.slave (AW, W, B, AR, R channels)
// Config:  AXI_WRAP_BURST_EN - when defined WRAP bursts are legal; otherwise
//          BURST=10 is answered with SLVERR, address held, no data moved.
module axi_modport_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input logic                ACLK,
    input logic                ARESETn,
    axi_modport_slave_if.slave bus
);
    localparam int STRB_W     = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(STRB_W);
    localparam int IDX_W      = $clog2(MEM_DEPTH);

`ifdef AXI_WRAP_BURST_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Burst-level legality: oversize beats, reserved burst type, bad WRAP length.
    function automatic logic burst_bad(input logic [2:0] size, input logic [1:0] burst,
                                       input logic [7:0] len);
        logic bad;
        bad = (size > 3'(BYTE_SHIFT));
        case (burst)
            2'b00, 2'b01: ;
            2'b10: if (!WRAP_EN || !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
                       bad = 1'b1;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Illegal bursts keep the address fixed so no neighbouring word is touched.
    function automatic logic [ADDR_WIDTH-1:0] addr_next(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst,
                                                        input logic [7:0] len,
                                                        input logic bad);
        logic [ADDR_WIDTH-1:0] step, wrap_mask, nxt;
        step      = ADDR_WIDTH'(1) << size;
        wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        nxt       = addr + step;
        if (bad || burst == 2'b00)
            nxt = addr;
        else if (burst == 2'b10)
            nxt = (addr & ~wrap_mask) | (nxt & wrap_mask);
        return nxt;
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >> BYTE_SHIFT) < ADDR_WIDTH'(MEM_DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        return addr[BYTE_SHIFT +: IDX_W];
    endfunction

    // Write path state
    w_state_t              w_state_q, w_state_d;
    logic [7:0]            awid_q, awid_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]            wlen_q, wlen_d;
    logic [7:0]            wcnt_q, wcnt_d;
    logic [2:0]            wsize_q, wsize_d;
    logic [1:0]            wburst_q, wburst_d;
    logic                  wbad_q, wbad_d;
    logic                  werr_q, werr_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  mem_we;

    // Read path state
    r_state_t              r_state_q, r_state_d;
    logic [7:0]            rid_q, rid_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [7:0]            rlen_q, rlen_d;
    logic [7:0]            rcnt_q, rcnt_d;
    logic [2:0]            rsize_q, rsize_d;
    logic [1:0]            rburst_q, rburst_d;
    logic                  rbad_q, rbad_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rlast_q, rlast_d;
    logic                  r_load;

    logic unused_wid;
    assign unused_wid = ^bus.WID;

    always_comb begin
        w_state_d = w_state_q;
        awid_d    = awid_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wcnt_d    = wcnt_q;
        wsize_d   = wsize_q;
        wburst_d  = wburst_q;
        wbad_d    = wbad_q;
        werr_d    = werr_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: if (bus.AWVALID && awready_q) begin
                w_state_d = W_DATA;
                awid_d    = bus.AWID;
                waddr_d   = bus.AWADDR;
                wlen_d    = bus.AWLEN;
                wcnt_d    = bus.AWLEN;
                wsize_d   = bus.AWSIZE;
                wburst_d  = bus.AWBURST;
                wbad_d    = burst_bad(bus.AWSIZE, bus.AWBURST, bus.AWLEN);
                werr_d    = wbad_d;
            end
            W_DATA: if (bus.WVALID && wready_q) begin
                mem_we = !wbad_q && in_range(waddr_q);
                // The beat counter, not WLAST, closes the burst; a disagreeing WLAST is an error.
                werr_d = werr_q || !mem_we || (bus.WLAST != (wcnt_q == 8'd0));
                if (wcnt_q == 8'd0) begin
                    w_state_d = W_RESP;
                    bresp_d   = werr_d ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    wcnt_d  = wcnt_q - 8'd1;
                    waddr_d = addr_next(waddr_q, wsize_q, wburst_q, wlen_q, wbad_q);
                end
            end
            W_RESP: if (bus.BREADY && bvalid_q) begin
                w_state_d = W_IDLE;
                bresp_d   = RESP_OKAY;
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rcnt_d    = rcnt_q;
        rsize_d   = rsize_q;
        rburst_d  = rburst_q;
        rbad_d    = rbad_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        r_load    = 1'b0;
        case (r_state_q)
            R_IDLE: if (bus.ARVALID && arready_q) begin
                r_state_d = R_DATA;
                rid_d     = bus.ARID;
                raddr_d   = bus.ARADDR;
                rlen_d    = bus.ARLEN;
                rcnt_d    = bus.ARLEN;
                rsize_d   = bus.ARSIZE;
                rburst_d  = bus.ARBURST;
                rbad_d    = burst_bad(bus.ARSIZE, bus.ARBURST, bus.ARLEN);
                r_load    = 1'b1;
            end
            R_DATA: if (bus.RREADY && rvalid_q) begin
                if (rcnt_q == 8'd0) begin
                    r_state_d = R_IDLE;
                    rdata_d   = '0;
                    rresp_d   = RESP_OKAY;
                    rlast_d   = 1'b0;
                end else begin
                    rcnt_d  = rcnt_q - 8'd1;
                    raddr_d = addr_next(raddr_q, rsize_q, rburst_q, rlen_q, rbad_q);
                    r_load  = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        // Memory is sampled before this edge's write lands, so a same-cycle
        // write to the same word is seen by the following beat, not this one.
        if (r_load) begin
            rlast_d = (rcnt_d == 8'd0);
            if (rbad_d || !in_range(raddr_d)) begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end else begin
                rdata_d = mem[word_idx(raddr_d)];
                rresp_d = RESP_OKAY;
            end
        end
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            w_state_q <= W_IDLE;
            awid_q    <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wbad_q    <= 1'b0;
            werr_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            r_state_q <= R_IDLE;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rbad_q    <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awid_q    <= awid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wbad_q    <= wbad_d;
            werr_q    <= werr_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            rid_q     <= rid_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rbad_q    <= rbad_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    // Memory has no reset; a write can only fire from W_DATA, which reset leaves.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (bus.WSTRB[b])
                    mem[word_idx(waddr_q)][8*b +: 8] <= bus.WDATA[8*b +: 8];
            end
        end
    end

    assign bus.AWREADY = awready_q;
    assign bus.WREADY  = wready_q;
    assign bus.BID     = awid_q;
    assign bus.BRESP   = bresp_q;
    assign bus.BVALID  = bvalid_q;
    assign bus.ARREADY = arready_q;
    assign bus.RID     = rid_q;
    assign bus.RDATA   = rdata_q;
    assign bus.RRESP   = rresp_q;
    assign bus.RLAST   = rlast_q;
    assign bus.RVALID  = rvalid_q;
endmodule

// File: tb/tb_axi_modport_slave.sv
// tb/tb_axi_modport_slave.sv - scoreboard bench for axi_modport_slave
module tb_axi_modport_slave;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_modport_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
    axi_modport_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
        .ACLK(clk), .ARESETn(rst), .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [7:0]  id;
    } r_exp_t;

    r_exp_t      r_q[$];
    logic [9:0]  b_q[$];
    logic [31:0] wd [16];

    logic        stalled = 1'b0;
    logic [42:0] snap    = '0;

    // R monitor: compares each beat and checks payload stability while stalled.
    always @(negedge clk) begin
        r_exp_t e;
        if (bus.RVALID && stalled)
            chk("r_stable", {bus.RID, bus.RDATA, bus.RRESP, bus.RLAST}, snap);
        stalled <= bus.RVALID && !bus.RREADY;
        snap    <= {bus.RID, bus.RDATA, bus.RRESP, bus.RLAST};
        if (bus.RVALID && bus.RREADY) begin
            if (r_q.size() == 0) begin
                chk("r_pending", r_q.size(), 1);
            end else begin
                e = r_q.pop_front();
                chk("rdata", bus.RDATA, e.data);
                chk("rresp", bus.RRESP, e.resp);
                chk("rlast", bus.RLAST, e.last);
                chk("rid",   bus.RID,   e.id);
            end
        end
    end

    always @(negedge clk) begin
        logic [9:0] e;
        if (bus.BVALID && bus.BREADY) begin
            if (b_q.size() == 0) begin
                chk("b_pending", b_q.size(), 1);
            end else begin
                e = b_q.pop_front();
                chk("bid",   bus.BID,   e[9:2]);
                chk("bresp", bus.BRESP, e[1:0]);
            end
        end
    end

    function automatic logic [63:0] all_outs();
        return 64'({bus.AWREADY, bus.WREADY, bus.BVALID, bus.BID, bus.BRESP, bus.ARREADY,
                    bus.RVALID, bus.RID, bus.RDATA, bus.RRESP, bus.RLAST});
    endfunction

    task automatic exp_r(input logic [31:0] data, input logic [1:0] resp, input logic last,
                         input logic [7:0] id);
        r_exp_t e;
        e.data = data; e.resp = resp; e.last = last; e.id = id;
        r_q.push_back(e);
    endtask

    task automatic wait_ready(input string tag, input int sel);
        int   k;
        logic r;
        k = 0;
        forever begin
            @(negedge clk);
            r = (sel == 0) ? bus.AWREADY : (sel == 1) ? bus.WREADY : bus.ARREADY;
            if (r || k >= 100) break;
            k++;
        end
        chk(tag, r, 1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((r_q.size() != 0 || b_q.size() != 0) && k < 200) begin
            @(posedge clk);
            k++;
        end
        chk("drain", r_q.size() + b_q.size(), 0);
    endtask

    task automatic wr(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                      input bit early_last, input logic [1:0] exp_resp);
        b_q.push_back({id, exp_resp});
        @(posedge clk); #1;
        bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size;
        bus.AWBURST = burst; bus.AWVALID = 1'b1;
        wait_ready("awready", 0);
        @(posedge clk); #1;
        bus.AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.WDATA  = wd[i];
            bus.WSTRB  = strb;
            bus.WLAST  = early_last ? (i == 0) : (i == int'(len));
            bus.WVALID = 1'b1;
            wait_ready("wready", 1);
            @(posedge clk); #1;
        end
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        drain();
    endtask

    task automatic rd(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
        @(posedge clk); #1;
        bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = size;
        bus.ARBURST = burst; bus.ARVALID = 1'b1;
        wait_ready("arready", 2);
        @(posedge clk); #1;
        bus.ARVALID = 1'b0;
    endtask

    task automatic exp_incr_block(input logic [7:0] id);
        exp_r(32'h11, 2'b00, 1'b0, id);
        exp_r(32'h22, 2'b00, 1'b0, id);
        exp_r(32'h33, 2'b00, 1'b0, id);
        exp_r(32'h44, 2'b00, 1'b1, id);
    endtask

    initial begin
        logic bseen;
        bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
        bus.AWVALID = 1'b0; bus.WID = '0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0;
        bus.WVALID = 1'b0; bus.BREADY = 1'b1; bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0;
        bus.ARSIZE = '0; bus.ARBURST = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b1;

        // Reset held three cycles, outputs all low throughout.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", all_outs(), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("awready_pre_edge", bus.AWREADY, 0);
        @(negedge clk);
        chk("awready_post", bus.AWREADY, 1);
        chk("arready_post", bus.ARREADY, 1);

        // INCR write/read of 0x10..0x1C.
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        wr(8'd5, 32'h10, 8'd3, 3'd2, 2'b01, 4'hF, 1'b0, 2'b00);
        exp_incr_block(8'd7);
        rd(8'd7, 32'h10, 8'd3, 3'd2, 2'b01);
        drain();

        // Byte strobes.
        wd[0] = 32'hAABBCCDD;
        wr(8'd1, 32'h0, 8'd0, 3'd2, 2'b01, 4'hF, 1'b0, 2'b00);
        wd[0] = 32'h0;
        wr(8'd2, 32'h0, 8'd0, 3'd2, 2'b01, 4'b0101, 1'b0, 2'b00);
        exp_r(32'hAA00CC00, 2'b00, 1'b1, 8'd3);
        rd(8'd3, 32'h0, 8'd0, 3'd2, 2'b01);
        drain();

        // WRAP read starting at 0x18 over a 16-byte window.
`ifdef AXI_WRAP_BURST_EN
        exp_r(32'h33, 2'b00, 1'b0, 8'd4);
        exp_r(32'h44, 2'b00, 1'b0, 8'd4);
        exp_r(32'h11, 2'b00, 1'b0, 8'd4);
        exp_r(32'h22, 2'b00, 1'b1, 8'd4);
`else
        exp_r(32'h0, 2'b10, 1'b0, 8'd4);
        exp_r(32'h0, 2'b10, 1'b0, 8'd4);
        exp_r(32'h0, 2'b10, 1'b0, 8'd4);
        exp_r(32'h0, 2'b10, 1'b1, 8'd4);
`endif
        rd(8'd4, 32'h18, 8'd3, 3'd2, 2'b10);
        drain();

        // Out-of-range read and write; word 0 must not be aliased.
        exp_r(32'h0, 2'b10, 1'b1, 8'd12);
        rd(8'd12, DEPTH * 4, 8'd0, 3'd2, 2'b01);
        drain();
        wd[0] = 32'h12345678;
        wr(8'd6, DEPTH * 4, 8'd0, 3'd2, 2'b01, 4'hF, 1'b0, 2'b10);
        exp_r(32'hAA00CC00, 2'b00, 1'b1, 8'd13);
        rd(8'd13, 32'h0, 8'd0, 3'd2, 2'b01);
        drain();

        // WLAST on the wrong beat, and an oversize read.
        wd[0] = 32'h5; wd[1] = 32'h6;
        wr(8'd8, 32'h20, 8'd1, 3'd2, 2'b01, 4'hF, 1'b1, 2'b10);
        exp_r(32'h0, 2'b10, 1'b1, 8'd9);
        rd(8'd9, 32'h10, 8'd0, 3'd3, 2'b01);
        drain();

        // RREADY 1-0-0-1 mid-burst.
        exp_incr_block(8'd10);
        rd(8'd10, 32'h10, 8'd3, 3'd2, 2'b01);
        @(posedge clk); #1;
        bus.RREADY = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.RREADY = 1'b1;
        drain();

        // Reset during W_DATA aborts the burst without a response.
        @(posedge clk); #1;
        bus.AWID = 8'd11; bus.AWADDR = 32'h40; bus.AWLEN = 8'd3; bus.AWSIZE = 3'd2;
        bus.AWBURST = 2'b01; bus.AWVALID = 1'b1;
        wait_ready("awready_abort", 0);
        @(posedge clk); #1;
        bus.AWVALID = 1'b0;
        bus.WDATA = 32'h55; bus.WSTRB = 4'hF; bus.WLAST = 1'b0; bus.WVALID = 1'b1;
        wait_ready("wready_abort", 1);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.WVALID = 1'b0;
        @(negedge clk);
        chk("rst_mid_outs", all_outs(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bseen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            bseen = bseen | bus.BVALID;
        end
        chk("no_bvalid", bseen, 0);
        chk("wready_idle", bus.WREADY, 0);
        chk("awready_idle", bus.AWREADY, 1);
        exp_incr_block(8'd14);
        rd(8'd14, 32'h10, 8'd3, 3'd2, 2'b01);
        drain();
        exp_r(32'hAA00CC00, 2'b00, 1'b1, 8'd15);
        rd(8'd15, 32'h0, 8'd0, 3'd2, 2'b01);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
